// File: rtl/hash_round_sequencer_pkg.sv
// Shared types and round-limit constants for the hash round sequencer.
package hash_round_sequencer_pkg;

  typedef enum logic [1:0] {
    MD5            = 2'd0,
    SHA_1          = 2'd1,
    SHA_256        = 2'd2,
    OPCODE_RESERVE = 2'd3
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  // Index of the last round for each algorithm.
  localparam int MD5_LAST    = 63;
  localparam int SHA1_LAST   = 79;
  localparam int SHA256_LAST = 63;

endpackage

// File: rtl/hash_round_sequencer_limit.sv
// Combinational opcode -> last-round-index lookup.
module hash_round_limit
  import hash_round_sequencer_pkg::*;
#(
  parameter int ROUND_W = 8
) (
  input  opcode_t              opcode_i,
  output logic [ROUND_W-1:0]   last_o
);

  // Reserved opcode never reaches ROUND; give it the short limit anyway.
  always_comb begin
    last_o = ROUND_W'(MD5_LAST);
    unique case (opcode_i)
      MD5:     last_o = ROUND_W'(MD5_LAST);
      SHA_1:   last_o = ROUND_W'(SHA1_LAST);
      SHA_256: last_o = ROUND_W'(SHA256_LAST);
      default: last_o = ROUND_W'(MD5_LAST);
    endcase
  end

endmodule

// File: rtl/hash_round_sequencer.sv
// Round/opcode initiator for the hash core: accept, load words, step rounds,
// finalize, done. Optional cycle counter built when HASH_SEQ_PERF_EN is defined.
module hash_round_sequencer
  import hash_round_sequencer_pkg::*;
#(
  parameter int ROUND_W = 8,
  parameter int WORDS   = 16,
  parameter int CYC_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         opcode_in,
  input  logic               w_valid,
  output logic               w_ready,
  output logic [3:0]         w_idx,
  input  logic               advance,
  output logic [1:0]         opcode,
  output logic [ROUND_W-1:0] round,
  output logic               round_valid,
  output logic               finalize,
  output logic               done,
  output logic               busy,
  output logic               err
`ifdef HASH_SEQ_PERF_EN
  ,
  output logic [CYC_W-1:0]   cycles
`endif
);

  seq_state_t           state_q, state_d;
  opcode_t              opcode_q, opcode_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [3:0]           w_idx_q, w_idx_d;
  logic                 err_q, err_d;
  logic                 w_ready_q, round_valid_q, finalize_q, done_q, busy_q;
  logic [ROUND_W-1:0]   last;
  logic                 accept;

  hash_round_limit #(.ROUND_W(ROUND_W)) u_limit (
    .opcode_i (opcode_q),
    .last_o   (last)
  );

  // Next-state, counters and request decode.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    round_d  = round_q;
    w_idx_d  = w_idx_q;
    err_d    = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (opcode_t'(opcode_in) == OPCODE_RESERVE) begin
            err_d = 1'b1;
          end else begin
            accept   = 1'b1;
            opcode_d = opcode_t'(opcode_in);
            w_idx_d  = '0;
            round_d  = '0;
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        if (w_valid && w_ready_q) begin
          w_idx_d = w_idx_q + 4'd1;
          if (w_idx_q == 4'(WORDS - 1)) begin
            round_d = '0;
            state_d = ROUND;
          end
        end
      end
      ROUND: begin
        // Stall holds round; the last round exits without wrapping.
        if (advance) begin
          if (round_q == last) state_d = FINAL;
          else                 round_d = round_q + ROUND_W'(1);
        end
      end
      FINAL: state_d = DONE;
      DONE: begin
        round_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered status outputs decoded from next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      opcode_q      <= MD5;
      round_q       <= '0;
      w_idx_q       <= '0;
      err_q         <= 1'b0;
      w_ready_q     <= 1'b0;
      round_valid_q <= 1'b0;
      finalize_q    <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      round_q       <= round_d;
      w_idx_q       <= w_idx_d;
      err_q         <= err_d;
      w_ready_q     <= (state_d == LOAD);
      round_valid_q <= (state_d == ROUND);
      finalize_q    <= (state_d == FINAL);
      done_q        <= (state_d == DONE);
      busy_q        <= (state_d == LOAD) || (state_d == ROUND) || (state_d == FINAL);
    end
  end

`ifdef HASH_SEQ_PERF_EN
  logic [CYC_W-1:0] cycles_q;

  // Busy-cycle counter: cleared on accept, saturating, idle at done.
  always_ff @(posedge clk) begin
    if (reset)                          cycles_q <= '0;
    else if (accept)                    cycles_q <= '0;
    else if (busy_q && (cycles_q != '1)) cycles_q <= cycles_q + CYC_W'(1);
  end

  assign cycles = cycles_q;
`endif

  assign w_ready     = w_ready_q;
  assign w_idx       = w_idx_q;
  assign opcode      = opcode_q;
  assign round       = round_q;
  assign round_valid = round_valid_q;
  assign finalize    = finalize_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_hash_round_sequencer.sv
// Directed scoreboard bench for hash_round_sequencer (HASH_SEQ_PERF_EN optional).
module tb_hash_round_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] opcode_in;
  logic       w_valid;
  logic       w_ready;
  logic [3:0] w_idx;
  logic       advance;
  logic [1:0] opcode;
  logic [7:0] round;
  logic       round_valid;
  logic       finalize;
  logic       done;
  logic       busy;
  logic       err;
`ifdef HASH_SEQ_PERF_EN
  logic [15:0] cycles;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] op;
    int         last;
    int         total;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  hash_round_sequencer #(.ROUND_W(8), .WORDS(16), .CYC_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .opcode_in   (opcode_in),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_idx       (w_idx),
    .advance     (advance),
    .opcode      (opcode),
    .round       (round),
    .round_valid (round_valid),
    .finalize    (finalize),
    .done        (done),
    .busy        (busy),
    .err         (err)
`ifdef HASH_SEQ_PERF_EN
    ,
    .cycles      (cycles)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one block from IDLE; returns in the DONE cycle (or after the bound).
  task automatic run_block(input logic [1:0] op, input int exp_last, input int exp_total,
                           input bit stall, input logic [31:0] gap_mask, input bit poke);
    exp_t e;
    int n = 1, rv_cnt = 0, fin_cnt = 0, busy_cnt = 0, load_cyc = 0;
    int stall_left = 0, idx_m = 0, max_rnd = 0;
    bit stalled_once = 0, adv_was_low = 0, got_done = 0;
    sb.push_back('{op: op, last: exp_last, total: exp_total});
    start = 1'b1; opcode_in = op; w_valid = 1'b1; advance = 1'b1;
    tick();
    start = 1'b0;
    n = 2;
    while (n < 400) begin
      if (done) begin got_done = 1; break; end
      busy_cnt += int'(busy);
      fin_cnt  += int'(finalize);
      if (round_valid) begin
        rv_cnt++;
        if (int'(round) > max_rnd) max_rnd = int'(round);
      end
      if (busy) chk("opcode_held", 32'(opcode), 32'(op));
      if (adv_was_low) chk("stall_round_hold", 32'(round), 32'd10);
      // drive inputs for this cycle's edge
      start = 1'b0; advance = 1'b1;
      if (w_ready) begin
        w_valid = (load_cyc < 32) ? !gap_mask[load_cyc] : 1'b1;
        chk("w_idx", 32'(w_idx), 32'(idx_m));
        if (w_valid) idx_m++;
        load_cyc++;
      end
      if (stall && round_valid && round == 8'd10 && !stalled_once) begin
        stall_left = 3; stalled_once = 1;
      end
      if (stall_left > 0) begin advance = 1'b0; stall_left--; end
      adv_was_low = !advance;
      if (poke && round_valid && round == 8'd20) begin
        start = 1'b1; opcode_in = (op == 2'd1) ? 2'd0 : 2'd1;
      end
      tick();
      n++;
    end
    chk("done_seen", 32'(got_done), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("done_cycle", 32'(n), 32'(e.total));
      chk("max_round", 32'(max_rnd), 32'(e.last));
      chk("round_cycles", 32'(rv_cnt), 32'(e.last + 1 + (stall ? 3 : 0)));
      chk("opcode_at_done", 32'(opcode), 32'(e.op));
      chk("busy_cycles", 32'(busy_cnt), 32'(e.total - 2));
    end
    chk("finalize_cnt", 32'(fin_cnt), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("words_loaded", 32'(idx_m), 32'd16);
`ifdef HASH_SEQ_PERF_EN
    chk("perf_cycles", 32'(cycles), 32'(busy_cnt));
`endif
    start = 1'b0; w_valid = 1'b0; advance = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_w_ready"}, 32'(w_ready), 32'd0);
    chk({tag, "_round_valid"}, 32'(round_valid), 32'd0);
    chk({tag, "_round"}, 32'(round), 32'd0);
    chk({tag, "_opcode"}, 32'(opcode), 32'd0);
    chk({tag, "_w_idx"}, 32'(w_idx), 32'd0);
    chk({tag, "_finalize"}, 32'(finalize), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
`ifdef HASH_SEQ_PERF_EN
    chk({tag, "_cycles"}, 32'(cycles), 32'd0);
`endif
  endtask

  initial begin
    int k;
    int dcnt;
    reset = 1'b1; start = 1'b0; opcode_in = 2'd0; w_valid = 1'b0; advance = 1'b1;
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // MD5, continuous words and advance: 83 cycles
    run_block(2'd0, 63, 83, 1'b0, 32'h0, 1'b0);
    // start seen in DONE is ignored
    start = 1'b1; opcode_in = 2'd2;
    tick();
    chk("done_start_w_ready", 32'(w_ready), 32'd0);
    chk("done_start_busy", 32'(busy), 32'd0);
    start = 1'b0;
    tick();
    chk("done_start_idle", 32'(w_ready), 32'd0);

    // SHA_1 with a stray start in ROUND: 99 cycles, opcode stays SHA_1
    run_block(2'd1, 79, 99, 1'b0, 32'h0, 1'b1);
    tick();

    // SHA_256 with 3-cycle stall at round 10
    run_block(2'd2, 63, 86, 1'b1, 32'h0, 1'b0);
    tick();

    // reserved opcode rejected
    start = 1'b1; opcode_in = 2'd3;
    tick();
    start = 1'b0;
    chk("rsv_err", 32'(err), 32'd1);
    chk("rsv_busy", 32'(busy), 32'd0);
    chk("rsv_w_ready", 32'(w_ready), 32'd0);
    chk("rsv_opcode", 32'(opcode), 32'd2);
    tick();
    chk("rsv_err_pulse", 32'(err), 32'd0);
    chk("rsv_busy2", 32'(busy), 32'd0);
    chk("rsv_w_ready2", 32'(w_ready), 32'd0);

    // w_valid gaps on LOAD cycles 1,3,5
    run_block(2'd0, 63, 86, 1'b0, 32'h0000_002A, 1'b0);
    tick();

    // reset at round 40 aborts without done
    start = 1'b1; opcode_in = 2'd1; w_valid = 1'b1; advance = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (k < 200 && !(round_valid && round == 8'd40)) begin
      tick(); k++;
    end
    chk("reach_round40", 32'(round), 32'd40);
    reset = 1'b1;
    tick();
    chk_all_zero("midreset");
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      dcnt += int'(done) + int'(busy);
    end
    chk("no_done_after_reset", 32'(dcnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
